disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_disp_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 8-digit multiplexed 7-segment scanner with manual/auto display-source selection
module disp_scan_ctrl #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [25:0] DWELL    = 26'd50000000,
    parameter logic [19:0] DEB_CYC  = 20'd500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_data,
    input  logic [2:0]  man_sel,
    input  logic        auto_en,
    input  logic        step_btn,
    output logic [2:0]  disp_sel,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_e;

    mode_e       state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [25:0] dwell_q, dwell_d;
    logic [1:0]  sync_q;
    logic        deb_q, deb_d;
    logic [19:0] deb_cnt_q, deb_cnt_d;
    logic [15:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] snap_q, snap_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        deb_accept, step_pulse, dwell_done, scan_tick;
    logic [3:0]  nib;

    // debouncer: the synchronised level must differ from the accepted level for DEB_CYC samples in a row
    always_comb begin
        deb_accept = (sync_q[1] != deb_q) && (deb_cnt_q == DEB_CYC - 20'd1);
        step_pulse = deb_accept & sync_q[1];
        deb_d      = deb_accept ? sync_q[1] : deb_q;
        deb_cnt_d  = (sync_q[1] == deb_q || deb_accept) ? 20'd0 : deb_cnt_q + 20'd1;
    end

    // two-flop synchroniser and debounce state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b00;
            deb_q     <= 1'b0;
            deb_cnt_q <= 20'd0;
        end else begin
            sync_q    <= {sync_q[0], step_btn};
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // mode FSM next state and source select; one advance per cycle even if dwell and step coincide
    always_comb begin
        dwell_done = dwell_q == DWELL - 26'd1;
        state_d    = auto_en ? AUTO : MANUAL;
        sel_d      = sel_q;
        dwell_d    = 26'd0;
        if (state_q == MANUAL)
            sel_d = auto_en ? ((sel_q == 3'b111) ? 3'b000 : sel_q) : man_sel;
        else if (dwell_done || step_pulse)
            sel_d = (sel_q == 3'b110) ? 3'b000 : sel_q + 3'd1;
        else
            dwell_d = dwell_q + 26'd1;
    end

    // mode, source select and dwell registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MANUAL;
            sel_q   <= 3'b000;
            dwell_q <= 26'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
        end
    end

    // digit prescaler, digit index and frame snapshot taken as the index wraps 7->0
    always_comb begin
        scan_tick = presc_q == SCAN_DIV - 16'd1;
        presc_d   = scan_tick ? 16'd0 : presc_q + 16'd1;
        idx_d     = scan_tick ? idx_q + 3'd1 : idx_q;
        snap_d    = (scan_tick && idx_q == 3'd7) ? disp_data : snap_q;
        nib       = snap_q[{idx_q, 2'b00} +: 4];
        an_d      = ~(8'b1 << idx_q);
        dp_d      = !(idx_q == 3'd0 && state_q == AUTO);
    end

    // hex to active-low segment decode, g..a
    always_comb begin
        case (nib)
            4'h0:    seg_d = 7'h40;
            4'h1:    seg_d = 7'h79;
            4'h2:    seg_d = 7'h24;
            4'h3:    seg_d = 7'h30;
            4'h4:    seg_d = 7'h19;
            4'h5:    seg_d = 7'h12;
            4'h6:    seg_d = 7'h02;
            4'h7:    seg_d = 7'h78;
            4'h8:    seg_d = 7'h00;
            4'h9:    seg_d = 7'h10;
            4'hA:    seg_d = 7'h08;
            4'hB:    seg_d = 7'h03;
            4'hC:    seg_d = 7'h46;
            4'hD:    seg_d = 7'h21;
            4'hE:    seg_d = 7'h06;
            default: seg_d = 7'h0E;
        endcase
    end

    // scan state and registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= 16'd0;
            idx_q   <= 3'd0;
            snap_q  <= 32'd0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign disp_sel = sel_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: vector tables, directed corner sequences and random stimulus against a cycle-count model
module tb_disp_scan_ctrl;
    localparam int SD = 4;
    localparam int DW = 20;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] disp_data;
    logic [2:0]  man_sel;
    logic        auto_en;
    logic        step_btn;
    logic [2:0]  disp_sel;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    disp_scan_ctrl #(.SCAN_DIV(16'd4), .DWELL(26'd20), .DEB_CYC(20'd3)) dut (
        .clk(clk), .reset(reset), .disp_data(disp_data), .man_sel(man_sel),
        .auto_en(auto_en), .step_btn(step_btn), .disp_sel(disp_sel),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model: scan position follows from the number of clocks since reset
    int         m_cyc, m_sel, m_dwell, d;
    bit         m_auto, m_s1, m_s2, m_acc, pulse, all_diff;
    bit         m_hist [DB];
    logic [31:0] m_snap;
    logic [7:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc = 0; m_sel = 0; m_dwell = 0; m_auto = 0;
            m_s1 = 0; m_s2 = 0; m_acc = 0;
            for (int i = 0; i < DB; i++) m_hist[i] = 0;
            m_snap = 0; m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1;
        end else begin
            d = (m_cyc / SD) % 8;
            for (int i = DB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_s2;
            all_diff = 1;
            for (int i = 0; i < DB; i++) if (m_hist[i] == m_acc) all_diff = 0;
            pulse = all_diff && !m_acc;
            if (all_diff) m_acc = !m_acc;
            m_an  = ~(8'b1 << d);
            m_seg = hex_tab[m_snap[4*d +: 4]];
            m_dp  = !(d == 0 && m_auto);
            if (!m_auto) begin
                m_sel = auto_en ? (m_sel == 7 ? 0 : m_sel) : int'(man_sel);
                m_dwell = 0;
            end else if (m_dwell == DW - 1 || pulse) begin
                m_sel = (m_sel + 1) % 7;
                m_dwell = 0;
            end else m_dwell++;
            if (m_cyc % (8 * SD) == 8 * SD - 1) m_snap = disp_data;
            m_auto = auto_en;
            m_cyc++;
            m_s2 = m_s1;
            m_s1 = step_btn;
        end
    end

    always @(negedge clk) if (chk_on) begin
        check("m_sel", 32'(disp_sel), m_sel);
        check("m_an", 32'(an), 32'(m_an));
        check("m_seg", 32'(seg), 32'(m_seg));
        check("m_dp", 32'(dp), 32'(m_dp));
    end

    typedef struct { logic [2:0] man; logic [2:0] exp_sel; } sel_vec_t;
    typedef struct { logic [31:0] data; logic [6:0] exp_seg; } seg_vec_t;
    sel_vec_t sel_tab [5];
    seg_vec_t seg_tab [16];
    logic [7:0] exp8;
    logic [6:0] exp7;
    int cnt0, dg;

    initial begin
        sel_tab[0] = '{3'b000, 3'b000};
        sel_tab[1] = '{3'b011, 3'b011};
        sel_tab[2] = '{3'b111, 3'b111};
        sel_tab[3] = '{3'b110, 3'b110};
        sel_tab[4] = '{3'b001, 3'b001};
        seg_tab[0]  = '{32'h00000000, 7'h40};
        seg_tab[1]  = '{32'h11111111, 7'h79};
        seg_tab[2]  = '{32'h22222222, 7'h24};
        seg_tab[3]  = '{32'h33333333, 7'h30};
        seg_tab[4]  = '{32'h44444444, 7'h19};
        seg_tab[5]  = '{32'h55555555, 7'h12};
        seg_tab[6]  = '{32'h66666666, 7'h02};
        seg_tab[7]  = '{32'h77777777, 7'h78};
        seg_tab[8]  = '{32'h88888888, 7'h00};
        seg_tab[9]  = '{32'h99999999, 7'h10};
        seg_tab[10] = '{32'hAAAAAAAA, 7'h08};
        seg_tab[11] = '{32'hBBBBBBBB, 7'h03};
        seg_tab[12] = '{32'hCCCCCCCC, 7'h46};
        seg_tab[13] = '{32'hDDDDDDDD, 7'h21};
        seg_tab[14] = '{32'hEEEEEEEE, 7'h06};
        seg_tab[15] = '{32'hFFFFFFFF, 7'h0E};
        man_sel = 0; auto_en = 0; step_btn = 0; disp_data = 0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 1);
        check("rst_sel", 32'(disp_sel), 0);
        man_sel = 3'b101;
        reset = 1;
        @(negedge clk);
        check("first_an", 32'(an), 32'hFE);
        check("first_seg", 32'(seg), 32'h40);
        check("man_latency", 32'(disp_sel), 32'h5);
        for (int k = 1; k <= 8; k++) begin
            repeat (SD) @(negedge clk);
            exp8 = ~(8'b1 << (k % 8));
            check("an_step", 32'(an), 32'(exp8));
        end
        for (int i = 0; i < 5; i++) begin
            man_sel = sel_tab[i].man;
            @(negedge clk);
            check("sel_tab", 32'(disp_sel), 32'(sel_tab[i].exp_sel));
        end
        for (int i = 0; i < 16; i++) begin
            disp_data = seg_tab[i].data;
            repeat (40) @(negedge clk);
            check("seg_tab", 32'(seg), 32'(seg_tab[i].exp_seg));
        end
        disp_data = 32'h0000001A;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            dg = ((m_cyc - 1) / SD) % 8;
            exp7 = dg == 0 ? 7'h08 : dg == 1 ? 7'h79 : 7'h40;
            check("frame_1a", 32'(seg), 32'(exp7));
        end
        man_sel = 3'b110;
        @(negedge clk);
        check("pre_auto", 32'(disp_sel), 32'h6);
        auto_en = 1;
        @(negedge clk);
        check("auto_entry", 32'(disp_sel), 32'h6);
        repeat (19) @(negedge clk);
        check("dwell_hold", 32'(disp_sel), 32'h6);
        @(negedge clk);
        check("dwell_wrap", 32'(disp_sel), 32'h0);
        repeat (19) @(negedge clk);
        check("dwell_hold2", 32'(disp_sel), 32'h0);
        @(negedge clk);
        check("dwell_adv", 32'(disp_sel), 32'h1);
        step_btn = 1;
        repeat (2) @(negedge clk);
        step_btn = 0;
        repeat (3) @(negedge clk);
        check("short_press", 32'(disp_sel), 32'h1);
        step_btn = 1;
        repeat (10) @(negedge clk);
        check("long_press", 32'(disp_sel), 32'h2);
        step_btn = 0;
        repeat (14) @(negedge clk);
        check("dwell_restart_hold", 32'(disp_sel), 32'h2);
        @(negedge clk);
        check("dwell_restart_adv", 32'(disp_sel), 32'h3);
        repeat (15) @(negedge clk);
        step_btn = 1;
        repeat (5) @(negedge clk);
        check("coincident_adv", 32'(disp_sel), 32'h4);
        repeat (5) @(negedge clk);
        step_btn = 0;
        repeat (14) @(negedge clk);
        check("coincident_hold", 32'(disp_sel), 32'h4);
        @(negedge clk);
        check("coincident_next", 32'(disp_sel), 32'h5);
        cnt0 = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (dp == 1'b0) cnt0++;
        end
        check("dp_slots", cnt0, SD);
        auto_en = 0;
        man_sel = 3'b011;
        repeat (2) @(negedge clk);
        auto_en = 1;
        repeat (3) @(negedge clk);
        check("pre_rst_sel", 32'(disp_sel), 32'h3);
        #2 reset = 0;
        #1;
        check("async_an", 32'(an), 32'hFF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 1);
        check("async_sel", 32'(disp_sel), 0);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("post_rst_dp", 32'(dp), 1);
        check("post_rst_sel", 32'(disp_sel), 0);
        @(negedge clk);
        check("post_rst_auto_dp", 32'(dp), 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            disp_data = $urandom;
            man_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            if (i == 1500) begin
                #2 reset = 0;
                #10 reset = 1;
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
